// File: rtl/glove_pkg.sv
// glove_pkg: gesture FSM states, slot count and 50 MHz timing shared by debouncer and draw stage
package glove_pkg;
   typedef enum logic [1:0] {ARMED, SETTLE, OFFER, HOLD} gesture_state_t;
   localparam int CLK_HZ = 50_000_000;
   localparam int STABLE_DEFAULT = CLK_HZ / 20;
   localparam int SLOTS_DEFAULT = 5;
   function automatic logic [2:0] next_slot(input logic [2:0] s, input int slots);
      return (32'(s) >= slots) ? 3'd1 : s + 3'd1;
   endfunction
endpackage

// File: rtl/gesture_debouncer_if.sv
// gesture_debouncer_if: valid/ready gesture offer from debouncer to draw stage
interface gesture_debouncer_if;
   logic valid;
   logic ready;
   logic [4:0] gesture;
   logic [2:0] slot;
   modport master(output valid, gesture, slot, input ready);
   modport slave(input valid, gesture, slot, output ready);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         meta <= '0;
         q <= '0;
      end else begin
         meta <= d;
         q <= meta;
      end
   end
endmodule

// File: rtl/gesture_debouncer.sv
// gesture_debouncer: settles glove finger codes and offers each new gesture once with a display slot
module gesture_debouncer
   import glove_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_DEFAULT,
   parameter int SLOTS = SLOTS_DEFAULT
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic [4:0]            finger_raw,
   output logic                  settling,
   gesture_debouncer_if.master   gif
);
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   gesture_state_t state;
   logic [4:0] sync;
   logic [4:0] cand;
   logic [CW-1:0] cnt;
   sync2 #(.WIDTH(5)) u_sync (.CLOCK_50(CLOCK_50), .resetn(resetn), .d(finger_raw), .q(sync));
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state <= ARMED;
         gif.valid <= 1'b0;
         gif.gesture <= '0;
         gif.slot <= 3'd1;
         cand <= '0;
         cnt <= '0;
         settling <= 1'b0;
      end else begin
         case (state)
            ARMED: if (sync != '0) begin
               cand <= sync;
               cnt <= '0;
               settling <= 1'b1;
               state <= SETTLE;
            end
            SETTLE: if (sync != cand) begin
               cand <= sync;
               cnt <= '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
               settling <= 1'b0;
               // a code that settles to all-open re-arms silently
               if (cand != '0) begin
                  gif.valid <= 1'b1;
                  gif.gesture <= cand;
                  state <= OFFER;
               end else begin
                  state <= ARMED;
               end
            end else if (cnt != '1) begin
               cnt <= cnt + 1'b1;
            end
            OFFER: if (gif.ready) begin
               gif.valid <= 1'b0;
               gif.slot <= next_slot(gif.slot, SLOTS);
               state <= HOLD;
            end
            HOLD: if (sync != gif.gesture) begin
               cand <= sync;
               cnt <= '0;
               settling <= 1'b1;
               state <= SETTLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_gesture_debouncer.sv
// tb_gesture_debouncer: vector table, corner sequences and random run against a timestamp model
module tb_gesture_debouncer;
   localparam int STABLE = 4;
   localparam int SLOTS = 5;
   logic CLOCK_50 = 1'b0;
   logic resetn;
   logic [4:0] finger_raw;
   logic settling;
   gesture_debouncer_if gif();
   gesture_debouncer #(.STABLE_CYCLES(STABLE), .SLOTS(SLOTS)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .finger_raw(finger_raw), .settling(settling), .gif(gif)
   );
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [4:0] raw;
      logic rdy;
      logic rn;
      logic v;
      logic [4:0] g;
      logic [2:0] s;
   } vec_t;
   typedef struct packed {
      logic [4:0] g;
      logic [2:0] s;
   } hs_t;
   vec_t tbl [10];
   hs_t hs [$];
   int n_checks = 0;
   int n_pass = 0;

   // model: a candidate is accepted when it has been seen unchanged STABLE edges after it was loaded
   bit m_watch, m_offer, m_hold;
   logic [4:0] m_cand, m_g, p1, p2;
   logic [2:0] m_slot;
   int t, m_load_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_edge(input logic [4:0] raw, input logic rdy, input logic rn);
      logic [4:0] s;
      s = p2;
      if (!rn) begin
         m_watch = 0; m_offer = 0; m_hold = 0;
         m_cand = 0; m_g = 0; m_slot = 1; p1 = 0; p2 = 0;
      end else begin
         if (m_offer) begin
            if (rdy) begin
               m_offer = 0;
               m_hold = 1;
               m_slot = (m_slot == 3'(SLOTS)) ? 3'd1 : m_slot + 3'd1;
            end
         end else if (m_watch) begin
            if (s != m_cand) begin
               m_cand = s;
               m_load_t = t;
            end else if (t - m_load_t == STABLE) begin
               m_watch = 0;
               m_hold = 0;
               if (m_cand != 0) begin
                  m_offer = 1;
                  m_g = m_cand;
               end
            end
         end else if (m_hold ? (s != m_g) : (s != 0)) begin
            m_watch = 1;
            m_cand = s;
            m_load_t = t;
         end
         p2 = p1;
         p1 = raw;
      end
      t++;
   endtask

   task automatic step(input logic [4:0] raw, input logic rdy, input logic rn);
      finger_raw = raw;
      gif.ready = rdy;
      resetn = rn;
      if (rn && gif.valid && rdy) hs.push_back({gif.gesture, gif.slot});
      model_edge(raw, rdy, rn);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      chk("model", 32'({gif.valid, gif.gesture, gif.slot, settling}), 32'({m_offer, m_g, m_slot, m_watch}));
   endtask

   task automatic do_reset();
      step(5'd0, 1'b0, 1'b0);
      hs.delete();
   endtask

   task automatic wait_valid(input logic [4:0] raw, input logic rdy, input string name);
      int n;
      n = 0;
      while (!gif.valid && n < 30) begin
         step(raw, rdy, 1'b1);
         n++;
      end
      if (!gif.valid) chk({name, "_timeout"}, 32'(gif.valid), 32'd1);
   endtask

   initial begin
      logic [4:0] gl [6];
      int n;
      resetn = 1'b0;
      finger_raw = '0;
      gif.ready = 1'b0;
      t = 0; m_load_t = 0;
      tbl = '{
         '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd1}, '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd1},
         '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd1}, '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd1},
         '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd1}, '{5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 3'd1},
         '{5'd1, 1'b1, 1'b1, 1'b1, 5'd1, 3'd1}, '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 3'd2},
         '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 3'd2}, '{5'd1, 1'b1, 1'b1, 1'b0, 5'd1, 3'd2}
      };
      @(negedge CLOCK_50);
      step(5'd0, 1'b0, 1'b0);
      step(5'd0, 1'b0, 1'b0);
      chk("reset_state", 32'({gif.valid, gif.gesture, gif.slot, settling}), 32'({1'b0, 5'd0, 3'd1, 1'b0}));
      hs.delete();
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].raw, tbl[i].rdy, tbl[i].rn);
         chk($sformatf("vec%0d", i), 32'({gif.valid, gif.gesture, gif.slot}), 32'({tbl[i].v, tbl[i].g, tbl[i].s}));
      end
      for (int i = 0; i < 10; i++) step(5'd1, 1'b1, 1'b1);
      chk("held_single_offer", 32'(hs.size()), 32'd1);

      do_reset();
      for (int i = 0; i < 20; i++) step(((i / 2) % 2) ? 5'b00010 : 5'b00011, 1'b1, 1'b1);
      chk("toggle_no_offer", 32'(hs.size()), 32'd0);
      for (int i = 0; i < 15; i++) step(5'b00010, 1'b1, 1'b1);
      chk("toggle_then_hold", 32'(hs.size()), 32'd1);
      if (hs.size() == 1) chk("toggle_gesture", 32'(hs[0]), 32'({5'b00010, 3'd1}));

      do_reset();
      wait_valid(5'b00100, 1'b0, "stall");
      for (int i = 0; i < 10; i++) begin
         step(5'b11111, 1'b0, 1'b1);
         chk("stall_hold", 32'({gif.valid, gif.gesture, gif.slot}), 32'({1'b1, 5'b00100, 3'd1}));
      end
      step(5'b11111, 1'b1, 1'b1);
      for (int i = 0; i < 15; i++) step(5'b11111, 1'b1, 1'b1);
      chk("stall_offers", 32'(hs.size()), 32'd2);
      if (hs.size() == 2) begin
         chk("stall_first", 32'(hs[0]), 32'({5'b00100, 3'd1}));
         chk("stall_second", 32'(hs[1]), 32'({5'b11111, 3'd2}));
      end

      do_reset();
      gl = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b10101};
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 12; i++) step(gl[k], 1'b1, 1'b1);
         for (int i = 0; i < 10; i++) step(5'd0, 1'b1, 1'b1);
      end
      chk("slots_count", 32'(hs.size()), 32'd6);
      for (int k = 0; k < 6 && k < hs.size(); k++)
         chk($sformatf("slot_wrap%0d", k), 32'(hs[k]), 32'({gl[k], 3'((k % SLOTS) + 1)}));

      do_reset();
      wait_valid(5'b01000, 1'b0, "rst_offer");
      step(5'b01000, 1'b0, 1'b0);
      chk("rst_offer_drop", 32'({gif.valid, gif.slot}), 32'({1'b0, 3'd1}));
      hs.delete();
      n = 0;
      while (!gif.valid && n < 30) begin
         step(5'b01000, 1'b1, 1'b1);
         n++;
      end
      chk("rst_resettle_latency", 32'(n), 32'd7);

      do_reset();
      for (int i = 0; i < 12; i++) step(5'b00100, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) step(5'b01100, 1'b1, 1'b1);
      chk("direct_count", 32'(hs.size()), 32'd2);
      if (hs.size() == 2) chk("direct_second", 32'(hs[1]), 32'({5'b01100, 3'd2}));

      do_reset();
      for (int r = 0; r < 300; r++) begin
         logic [4:0] v;
         int len;
         v = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++)
            step(v, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 199) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/gesture_debouncer.md
GESTURE_DEBOUNCER -- requirements
Module: gesture_debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 2500000: clock cycles the synchronized finger code must hold unchanged before it is accepted (50 ms at 50 MHz).
REQ-002 Parameter SLOTS, default 5: number of letter display positions before slot wraps.
REQ-003 CLOCK_50  input  1: the single clock; all logic on its rising edge.
REQ-004 resetn  input  1: reset, synchronous and active-low.
REQ-005 finger_raw  input  5: asynchronous glove flex-sensor bits, one per finger; 1 = finger bent.
REQ-006 ready  input  1: downstream draw stage is idle and can accept a gesture.
REQ-007 gesture  output  5: committed finger code, held constant while valid=1.
REQ-008 valid  output  1: gesture/slot offered to downstream; handshake completes on a cycle with valid=1 and ready=1.
REQ-009 slot  output  3: display position 1..SLOTS for the offered gesture.
REQ-010 settling  output  1: high while in SETTLE; for status LED.

Function
REQ-011 finger_raw SHALL pass through a two-flop synchronizer; all further logic uses the second flop (sync), giving 2 cycles input latency.
REQ-012 FSM states SHALL be ARMED, SETTLE, OFFER, HOLD, encoded in a 2-bit state register.
REQ-013 ARMED: when sync != 0, load candidate = sync, clear stable counter, go to SETTLE.
REQ-014 SETTLE: if sync != candidate, reload candidate = sync and clear counter (stay); else increment counter.
REQ-015 SETTLE: when counter reaches STABLE_CYCLES-1 with sync == candidate, go to OFFER if candidate != 0, else go to ARMED without offering.
REQ-016 OFFER: valid=1, gesture=candidate, slot=current slot; valid, gesture and slot SHALL NOT change until the handshake completes.
REQ-017 On handshake: slot advances (SLOTS wraps to 1), valid drops the next cycle, state goes to HOLD.
REQ-018 HOLD: no offers; when sync != gesture, load candidate = sync, clear counter, go to SETTLE; holding one gesture never produces a repeated letter.
REQ-019 A change in finger_raw during OFFER SHALL be ignored until the handshake completes.
REQ-020 Stable counter width SHALL be clog2(STABLE_CYCLES) bits and SHALL saturate, never wrap, in SETTLE.
REQ-021 ready is ignored outside OFFER; valid SHALL never assert outside OFFER.
REQ-022 A glitch shorter than STABLE_CYCLES SHALL restart settling and produce no offer.

Reset
REQ-023 resetn=0 at a clock edge SHALL force state=ARMED, valid=0, gesture=0, candidate=0, counter=0, slot=1, settling=0, synchronizer flops=0.
REQ-024 Reset during OFFER SHALL drop valid on the next edge with no handshake, and SHALL not advance slot.
REQ-025 After resetn returns high, an input already held nonzero SHALL be settled from scratch (full STABLE_CYCLES).

Structure
REQ-026 State encoding, SLOTS default and the 50 MHz timing constant SHALL live in shared package glove_pkg, also used by the draw stage.
REQ-027 The two-flop synchronizer SHALL be one sub-module, sync2, parameterised by width.
REQ-028 No other sub-modules; target 120-250 lines RTL.

Verification (STABLE_CYCLES=4, SLOTS=5)
REQ-029 Reset, finger_raw=00001 held, ready=1 -> valid high for one cycle with gesture=00001, slot=1, first asserted 2 sync + 4 settle + 1 transition cycles after input change; then no further valid while held.
REQ-030 finger_raw toggles 00011/00010 every 2 cycles for 20 cycles, then holds 00010 -> no valid during toggling; exactly one offer gesture=00010 after settling.
REQ-031 ready=0 during OFFER for 10 cycles while finger_raw changes to 11111 -> valid, gesture=original and slot stable all 10 cycles; handshake on ready=1; then 11111 settles and is offered.
REQ-032 Six distinct gestures, each separated by 00000, ready=1 -> slots 1,2,3,4,5,1; 00000 never offered.
REQ-033 resetn=0 for one cycle while valid=1, ready=0 -> valid=0 next cycle, slot=1, held input re-offered only after full settle.
REQ-034 Direct change 00100 -> 01100 without passing 00000 -> second gesture offered at slot+1.
